mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_if.sv | 40 ++++
 rtl/mem_responder.sv | 146 ++++++++++++++
 tb/tb_mem_responder.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Load/store bus and host byte-stream port of mem_responder.
// slave = responder side, master = CPU/host side.
interface mem_responder_if;
  logic [31:0] mem_addr_i;
  logic        mem_we_i;
  logic [7:0]  mem_wdata_i;
  logic [7:0]  mem_rdata_o;
  logic [7:0]  io_dout_o;
  logic        io_valid_o;
  logic        io_ready_i;
  logic        io_full_o;
  logic [7:0]  io_din_i;
  logic        io_din_valid_i;

  modport slave (
    input  mem_addr_i,
    input  mem_we_i,
    input  mem_wdata_i,
    output mem_rdata_o,
    output io_dout_o,
    output io_valid_o,
    input  io_ready_i,
    output io_full_o,
    input  io_din_i,
    input  io_din_valid_i
  );

  modport master (
    output mem_addr_i,
    output mem_we_i,
    output mem_wdata_i,
    input  mem_rdata_o,
    input  io_dout_o,
    input  io_valid_o,
    output io_ready_i,
    input  io_full_o,
    output io_din_i,
    output io_din_valid_i
  );
endinterface

// File: rtl/mem_responder.sv
// Byte RAM plus memory-mapped IO: TX byte queue, RX holding register.
// One-cycle registered reads; IO region selected by addr[17:16] == 2'b11.
module mem_responder #(
  parameter int          RAM_AW    = 17,
  parameter logic [31:0] IO_BASE   = 32'h0003_0000,
  parameter int          TXQ_DEPTH = 8
) (
  input logic           clk,
  input logic           rst,
  mem_responder_if.slave bus
);
  localparam int PW = $clog2(TXQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0]   IO_STAT  = IO_BASE + 32'd4;
  localparam logic [CW-1:0] FULL_CNT = CW'(TXQ_DEPTH);

  logic [7:0]        ram [2**RAM_AW];
  logic [7:0]        ram_q;
  logic [RAM_AW-1:0] ram_idx;

  logic [7:0]    txq [TXQ_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ovr;
  logic       tx_ovf;

  logic       sel_ram;
  logic [7:0] io_q;
  logic [7:0] io_byte;
  logic [7:0] stat_byte;

  logic is_io;
  logic rd;
  logic wr;
  logic hit_data;
  logic hit_stat;
  logic full;
  logic pop;
  logic push_req;
  logic push_ok;
  logic drop;

  assign is_io    = bus.mem_addr_i[17:16] == 2'b11;
  assign rd       = !bus.mem_we_i;
  assign wr       = bus.mem_we_i;
  assign ram_idx  = bus.mem_addr_i[RAM_AW-1:0];
  assign hit_data = is_io && (bus.mem_addr_i == IO_BASE);
  assign hit_stat = is_io && (bus.mem_addr_i == IO_STAT);

  assign full     = count == FULL_CNT;
  assign pop      = !rst && (count != '0) && bus.io_ready_i;
  assign push_req = !rst && wr && hit_data;
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  assign stat_byte = {4'b0, rx_ovr, tx_ovf, full, rx_valid};

  assign bus.io_dout_o  = txq[rd_ptr];
  assign bus.io_valid_o = count != '0;
  assign bus.io_full_o  = full;
  assign bus.mem_rdata_o = sel_ram ? ram_q : io_q;

  // RAM array: contents survive reset, read port only fires on reads
  always_ff @(posedge clk) begin
    if (wr && !is_io)
      ram[ram_idx] <= bus.mem_wdata_i;
    if (rd && !is_io)
      ram_q <= ram[ram_idx];
  end

  // IO read data select for the current address
  always_comb begin
    io_byte = 8'h00;
    unique case (1'b1)
      hit_data: io_byte = rx_data;
      hit_stat: io_byte = stat_byte;
      default:  io_byte = 8'h00;
    endcase
  end

  // Read source tracking; writes leave the output untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_ram <= 1'b0;
      io_q    <= 8'h00;
    end else if (rd) begin
      sel_ram <= !is_io;
      if (is_io)
        io_q <= io_byte;
    end
  end

  // TX queue storage, no reset needed behind count
  always_ff @(posedge clk) begin
    if (push_ok)
      txq[wr_ptr] <= bus.mem_wdata_i;
  end

  // TX queue pointers, occupancy and overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      tx_ovf <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr && hit_stat)
        tx_ovf <= 1'b0;
      else if (drop)
        tx_ovf <= 1'b1;
    end
  end

  // RX holding register; a new overrun wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      rx_ovr   <= 1'b0;
    end else begin
      if (rd && hit_data)
        rx_valid <= 1'b0;
      if (wr && hit_stat)
        rx_ovr <= 1'b0;
      if (bus.io_din_valid_i) begin
        rx_data  <= bus.io_din_i;
        rx_valid <= 1'b1;
        if (rx_valid)
          rx_ovr <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus random traffic
// checked every cycle against a queue/array reference model.
module tb_mem_responder;
  localparam logic [31:0] IOB = 32'h0003_0000;
  localparam logic [31:0] IOS = IOB + 32'd4;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_responder_if bus();

  mem_responder #(
    .RAM_AW(17),
    .IO_BASE(IOB),
    .TXQ_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // reference model state
  logic [7:0] m_ram [logic [16:0]];
  logic [7:0] q [$];
  logic [7:0] m_rx = 8'h00;
  bit         m_rxv = 0;
  bit         m_ovr = 0;
  bit         m_ovf = 0;
  logic [7:0] m_rd = 8'h00;
  bit         m_known = 0;

  logic [31:0] ma;
  logic        mw;
  logic [7:0]  mwd;
  logic        mrdy;
  logic        mdv;
  logic [7:0]  mdi;
  logic [7:0]  mstat;
  logic [7:0]  mtmp;
  bit          mio;
  bit          mpop;
  bit          mrxv_old;

  // model update at each edge, then compare outputs
  always begin
    @(posedge clk);
    ma = bus.mem_addr_i;
    mw = bus.mem_we_i;
    mwd = bus.mem_wdata_i;
    mrdy = bus.io_ready_i;
    mdv = bus.io_din_valid_i;
    mdi = bus.io_din_i;
    mio = ma[17:16] == 2'b11;
    if (mw && !mio) m_ram[ma[16:0]] = mwd;
    if (rst) begin
      m_rd = 8'h00;
      m_known = 1;
      q.delete();
      m_rx = 8'h00;
      m_rxv = 0;
      m_ovr = 0;
      m_ovf = 0;
    end else begin
      mstat = {4'b0, m_ovr, m_ovf, q.size() == DEPTH, m_rxv};
      mrxv_old = m_rxv;
      if (!mw) begin
        m_known = 1;
        if (!mio) begin
          if (m_ram.exists(ma[16:0])) m_rd = m_ram[ma[16:0]];
          else m_known = 0;
        end else if (ma == IOB) begin
          m_rd = m_rx;
          m_rxv = 0;
        end else if (ma == IOS) m_rd = mstat;
        else m_rd = 8'h00;
      end
      mpop = q.size() > 0 && mrdy;
      if (mpop) mtmp = q.pop_front();
      if (mw && ma == IOB) begin
        if (q.size() < DEPTH) q.push_back(mwd);
        else m_ovf = 1;
      end
      if (mw && ma == IOS) begin
        m_ovf = 0;
        m_ovr = 0;
      end
      if (mdv) begin
        if (mrxv_old) m_ovr = 1;
        m_rx = mdi;
        m_rxv = 1;
      end
    end
    #1;
    chk("io_valid", bus.io_valid_o, q.size() != 0);
    chk("io_full", bus.io_full_o, q.size() == DEPTH);
    if (q.size() != 0) chk("io_dout", bus.io_dout_o, q[0]);
    if (m_known) chk("mem_rdata", bus.mem_rdata_o, m_rd);
  end

  task automatic cyc(input logic [31:0] a, input logic w,
                     input logic [7:0] d, input logic rdy,
                     input logic dv, input logic [7:0] di,
                     input logic r);
    @(negedge clk);
    rst = r;
    bus.mem_addr_i = a;
    bus.mem_we_i = w;
    bus.mem_wdata_i = d;
    bus.io_ready_i = rdy;
    bus.io_din_valid_i = dv;
    bus.io_din_i = di;
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d,
                    input logic rdy);
    cyc(a, 1'b1, d, rdy, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a, input logic rdy);
    cyc(a, 1'b0, 8'h00, rdy, 1'b0, 8'h00, 1'b0);
  endtask

  logic [7:0] exp_seq [8];
  logic [31:0] r;
  logic [31:0] a;
  logic [16:0] idx;
  int sel;
  int rdy_pct;

  initial begin
    bus.mem_addr_i = 32'h0;
    bus.mem_we_i = 1'b0;
    bus.mem_wdata_i = 8'h00;
    bus.io_ready_i = 1'b0;
    bus.io_din_valid_i = 1'b0;
    bus.io_din_i = 8'h00;

    cyc(32'h104, 1'b0, 8'h00, 1'b1, 1'b1, 8'h55, 1'b1);
    cyc(IOB, 1'b1, 8'h66, 1'b1, 1'b1, 8'h55, 1'b1);
    chk("rst_rdata", bus.mem_rdata_o, 8'h00);
    chk("rst_valid", bus.io_valid_o, 1'b0);
    chk("rst_full", bus.io_full_o, 1'b0);

    wr(32'h104, 8'h5A, 1'b0);
    rd(32'h104, 1'b0);
    chk("ram_rd", bus.mem_rdata_o, 8'h5A);
    rd(32'h0002_0104, 1'b0);
    chk("ram_wrap", bus.mem_rdata_o, 8'h5A);
    wr(32'h104, 8'h99, 1'b0);
    chk("wr_hold", bus.mem_rdata_o, 8'h5A);
    wr(32'h104, 8'h5A, 1'b0);

    for (int i = 0; i < 4; i++) wr(32'h200 + i, 8'h11 * (i + 1), 1'b0);
    for (int i = 0; i < 4; i++) begin
      rd(32'h200 + i, 1'b0);
      chk("b2b_rd", bus.mem_rdata_o, 8'h11 * (i + 1));
    end

    for (int i = 1; i <= 9; i++) begin
      wr(IOB, 8'(i), 1'b0);
      if (i == 7) chk("not_full7", bus.io_full_o, 1'b0);
      if (i == 8) chk("full8", bus.io_full_o, 1'b1);
    end
    rd(IOS, 1'b0);
    chk("stat_ovf", bus.mem_rdata_o, 8'h06);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_dout", bus.io_dout_o, 8'(i));
      rd(32'h104, 1'b1);
    end
    chk("drain_empty", bus.io_valid_o, 1'b0);
    wr(IOS, 8'h00, 1'b0);

    for (int i = 0; i < 8; i++) wr(IOB, 8'h10 + 8'(i), 1'b0);
    wr(IOB, 8'hAA, 1'b1);
    chk("pp_full", bus.io_full_o, 1'b1);
    rd(IOS, 1'b0);
    chk("pp_stat", bus.mem_rdata_o, 8'h02);
    for (int i = 0; i < 7; i++) exp_seq[i] = 8'h11 + 8'(i);
    exp_seq[7] = 8'hAA;
    for (int i = 0; i < 8; i++) begin
      chk("pp_dout", bus.io_dout_o, exp_seq[i]);
      rd(32'h104, 1'b1);
    end
    chk("pp_empty", bus.io_valid_o, 1'b0);

    cyc(32'h104, 1'b0, 8'h00, 1'b0, 1'b1, 8'h41, 1'b0);
    cyc(32'h104, 1'b0, 8'h00, 1'b0, 1'b1, 8'h42, 1'b0);
    rd(IOS, 1'b0);
    chk("rx_stat_ovr", bus.mem_rdata_o, 8'h09);
    rd(IOB, 1'b0);
    chk("rx_data", bus.mem_rdata_o, 8'h42);
    rd(IOS, 1'b0);
    chk("rx_stat_rd", bus.mem_rdata_o, 8'h08);
    wr(IOS, 8'h00, 1'b0);
    rd(IOS, 1'b0);
    chk("rx_stat_clr", bus.mem_rdata_o, 8'h00);
    rd(IOB + 32'd8, 1'b0);
    chk("io_other", bus.mem_rdata_o, 8'h00);

    wr(32'h300, 8'h77, 1'b0);
    wr(IOB, 8'hA1, 1'b0);
    wr(IOB, 8'hA2, 1'b0);
    cyc(IOB, 1'b1, 8'hA3, 1'b0, 1'b1, 8'h33, 1'b1);
    chk("rst_mid_valid", bus.io_valid_o, 1'b0);
    rd(IOS, 1'b0);
    chk("rst_mid_stat", bus.mem_rdata_o, 8'h00);
    rd(32'h300, 1'b0);
    chk("rst_ram_keep", bus.mem_rdata_o, 8'h77);

    for (int i = 0; i < 16; i++) wr(32'h400 + i, 8'($urandom()), 1'b0);
    rdy_pct = 80;
    for (int n = 0; n < 3000; n++) begin
      if (n % 64 == 0) rdy_pct = (rdy_pct == 80) ? 10 : 80;
      r = $urandom();
      sel = $urandom_range(0, 9);
      idx = {r[0], 16'h0400 + 16'($urandom_range(0, 15))};
      if (sel <= 5)
        a = {r[31:18], idx[16] ? 1'b0 : r[17], idx};
      else if (sel <= 7) a = IOB;
      else if (sel == 8) a = IOS;
      else a = IOB + 32'd8;
      cyc(a,
          (sel == 8) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0),
          8'($urandom()),
          $urandom_range(0, 99) < rdy_pct,
          $urandom_range(0, 5) == 0,
          8'($urandom()),
          1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
